// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared constants for the register writeback arbiter
package reg_write_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Requester indices into the arbiter valid/grant vectors
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    // Register 0 is hardwired; writes and load tracking to it are discarded
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_write_arbiter_rr_arb2.sv
// rtl/reg_write_arbiter_rr_arb2.sv - two-way round-robin arbiter
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // Index of the requester that won the last contended cycle
    logic rr_last;

    // Lone requester wins outright; on a tie the one that did not win last time wins
    always_comb begin
        grant = valid;
        if (valid[0] && valid[1]) begin
            grant = rr_last ? 2'b01 : 2'b10;
        end
    end

    // History only advances on contended cycles; starts at 1 so index 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (valid[0] && valid[1]) begin
            rr_last <= grant[1];
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register bank write-port arbiter with load pending scoreboard
module reg_write_arbiter #(
    parameter int DATA_W  = reg_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W  = reg_write_arbiter_pkg::ADDR_W,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_pending,
    output logic              rt_pending,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        out_count
);

    import reg_write_arbiter_pkg::*;

    logic [1:0]             req_valid;
    logic [1:0]             req_grant;
    logic                   alu_xfer;
    logic                   ld_xfer;
    logic                   issue_set;
    logic                   ld_clear;
    logic [2**ADDR_W-1:0]   pending;

    assign req_valid[REQ_ALU] = alu_valid;
    assign req_valid[REQ_LD]  = ld_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .valid (req_valid),
        .grant (req_grant)
    );

    // Ready is the grant, forced low while the block is held in reset
    assign alu_ready = req_grant[REQ_ALU] & ~reset;
    assign ld_ready  = req_grant[REQ_LD]  & ~reset;
    assign alu_xfer  = alu_valid & alu_ready;
    assign ld_xfer   = ld_valid  & ld_ready;

    // Loads to r0 are accepted and forgotten; otherwise the register must be free and capacity left
    assign issue_ready = ~reset & ((issue_reg == REG_ZERO) |
                         (~pending[issue_reg] & (out_count < 4'(MAX_OUT))));
    assign issue_set   = issue_valid & issue_ready & (issue_reg != REG_ZERO);
    // A returning load only retires tracking state if it was actually outstanding
    assign ld_clear    = ld_xfer & pending[ld_addr];

    // Hazard lookup uses registered state only; a clear becomes visible with its write
    assign rs_pending = pending[rs_addr];
    assign rt_pending = pending[rt_addr];

    // Registered write port: one cycle after a transfer, suppressed for r0
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (alu_xfer) begin
            wr_en   <= (alu_addr != REG_ZERO);
            wr_addr <= alu_addr;
            wr_data <= alu_data;
        end else if (ld_xfer) begin
            wr_en   <= (ld_addr != REG_ZERO);
            wr_addr <= ld_addr;
            wr_data <= ld_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Pending scoreboard and outstanding count; set and clear never target the same register
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            out_count <= '0;
        end else begin
            if (ld_clear) begin
                pending[ld_addr] <= 1'b0;
            end
            if (issue_set) begin
                pending[issue_reg] <= 1'b1;
            end
            out_count <= out_count + {3'b000, issue_set} - {3'b000, ld_clear};
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed-vector bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_reg, rs_addr, rt_addr;
    logic        rs_pending, rt_pending;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  out_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_reg   (issue_reg),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_pending  (rs_pending),
        .rt_pending  (rt_pending),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .out_count   (out_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past a rising edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] alu_cnt, ld_cnt;
    logic        exp_alu;

    initial begin
        reset = 1'b1; alu_valid = 1'b1; alu_addr = 5'd0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        issue_valid = 1'b0; issue_reg = '0; rs_addr = '0; rt_addr = '0;

        // Reset held two cycles with a requester active
        tick(); tick();
        check("rst_alu_ready", alu_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_out_count", out_count, 0);
        check("rst_rs_pending", rs_pending, 0);
        check("rst_issue_ready", issue_ready, 0);
        reset = 1'b0; alu_valid = 1'b0;
        tick();

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF; #1;
        check("alu_ready", alu_ready, 1);
        check("alu_ld_ready", ld_ready, 0);
        tick();
        alu_valid = 1'b0;
        check("alu_wr_en", wr_en, 1);
        check("alu_wr_addr", wr_addr, 5);
        check("alu_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        check("alu_wr_en_drop", wr_en, 0);
        check("alu_wr_data_hold", wr_data, 32'hDEADBEEF);

        // Contention: ALU, LD, ALU, LD, fresh data after each grant
        alu_cnt = 0; ld_cnt = 0;
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'hA0000000;
        ld_valid  = 1'b1; ld_addr  = 5'd7; ld_data  = 32'hB0000000;
        for (int k = 0; k < 4; k++) begin
            exp_alu = (k % 2 == 0);
            #1;
            check("cont_alu_ready", alu_ready, exp_alu);
            check("cont_ld_ready", ld_ready, !exp_alu);
            tick();
            if (exp_alu) begin
                check("cont_wr_data", wr_data, 32'hA0000000 + alu_cnt);
                check("cont_wr_addr", wr_addr, 6);
                alu_cnt++; alu_data = 32'hA0000000 + alu_cnt;
            end else begin
                check("cont_wr_data", wr_data, 32'hB0000000 + ld_cnt);
                check("cont_wr_addr", wr_addr, 7);
                ld_cnt++; ld_data = 32'hB0000000 + ld_cnt;
            end
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        tick();
        check("cont_out_count", out_count, 0);

        // Scoreboard on r8
        issue_valid = 1'b1; issue_reg = 5'd8; #1;
        check("sb_issue_ready", issue_ready, 1);
        tick();
        rs_addr = 5'd8; #1;
        check("sb_rs_pending", rs_pending, 1);
        check("sb_out_count1", out_count, 1);
        check("sb_reissue_ready", issue_ready, 0);
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 32'h00C0FFEE; #1;
        check("sb_ld_ready", ld_ready, 1);
        check("sb_no_bypass", rs_pending, 1);
        tick();
        ld_valid = 1'b0; #1;
        check("sb_rs_cleared", rs_pending, 0);
        check("sb_wr_en", wr_en, 1);
        check("sb_wr_addr", wr_addr, 8);
        check("sb_wr_data", wr_data, 32'h00C0FFEE);
        check("sb_out_count0", out_count, 0);

        // Capacity: r1..r4 fill the tracker
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1'b1; issue_reg = 5'(r);
            tick();
        end
        issue_valid = 1'b0; #1;
        check("cap_out_count4", out_count, 4);
        issue_reg = 5'd0; #1;
        check("cap_r0_issue_ready", issue_ready, 1);
        issue_valid = 1'b1; issue_reg = 5'd9;
        ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 32'h22222222; #1;
        check("cap_full_ready", issue_ready, 0);
        check("cap_ld_ready", ld_ready, 1);
        tick();
        ld_valid = 1'b0; #1;
        check("cap_after_ret_ready", issue_ready, 1);
        check("cap_out_count3", out_count, 3);
        check("cap_ret_wr_addr", wr_addr, 2);
        tick();
        issue_valid = 1'b0;
        rs_addr = 5'd2; rt_addr = 5'd9; #1;
        check("cap_out_count_net", out_count, 4);
        check("cap_rt_pending9", rt_pending, 1);
        check("cap_rs_pending2", rs_pending, 0);

        // Write to r0 is accepted but not performed
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h12345678; #1;
        check("r0_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("r0_wr_en", wr_en, 0);

        // Return r3, reissue r3, then reset with writes in flight
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h33333333;
        tick();
        ld_valid = 1'b0;
        issue_valid = 1'b1; issue_reg = 5'd3;
        tick();
        issue_valid = 1'b0; rs_addr = 5'd3; #1;
        check("mid_rs_pending3", rs_pending, 1);
        check("mid_out_count", out_count, 4);
        reset = 1'b1; alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'hFFFF0000; #1;
        check("mid_rst_alu_ready", alu_ready, 0);
        tick();
        reset = 1'b0; alu_valid = 1'b0; #1;
        check("mid_wr_en", wr_en, 0);
        check("mid_wr_addr", wr_addr, 0);
        check("mid_out_count0", out_count, 0);
        check("mid_rs_cleared", rs_pending, 0);
        check("mid_rt_cleared", rt_pending, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Owns the single write port of the 32x32 register bank and shares it between two writeback requesters: the ALU result path (req0) and the load-return path (req1).
Tracks outstanding loads in a per-register pending scoreboard so decode can stall on RAW hazards.
Sits between the execute/memory stages and reg_bank. Its registered write outputs drive the bank's write address, write data and write enable directly.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers)
MAX_OUT, 4, maximum outstanding loads tracked (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
ld_valid  input  1  load-return writeback request
ld_ready  output  1  load request accepted this cycle
ld_addr  input  ADDR_W  load destination register
ld_data  input  DATA_W  load data
issue_valid  input  1  decode issues a load to issue_reg
issue_ready  output  1  load issue accepted
issue_reg  input  ADDR_W  load destination
rs_addr  input  ADDR_W  decode source register 1
rt_addr  input  ADDR_W  decode source register 2
rs_pending  output  1  rs_addr has an outstanding load
rt_pending  output  1  rt_addr has an outstanding load
wr_en  output  1  register bank write enable
wr_addr  output  ADDR_W  register bank write address
wr_data  output  DATA_W  register bank write data
out_count  output  4  number of outstanding loads

Behaviour:
- Clock, reset: one clock, clk. Reset is synchronous and active-high (reset=1 sampled on a rising clk edge).
- Reset values: wr_en=0, wr_addr=0, wr_data=0, pending mask=0, out_count=0, rr_last=1 (req0 wins the first tie).
- Ready signals during reset: alu_ready, ld_ready and issue_ready are 0 while reset=1.
- Arbitration (combinational):
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not equal to rr_last.
  - No requester valid: no grant.
  - readyX = grantX. Transfer = validX & readyX. Grant never depends on readyX.
- rr_last update: rr_last <= granted index only on cycles where both requested; otherwise unchanged.
- Requester hold rule: a requester must hold valid, addr and data stable until ready. The arbiter does not buffer.
- Write port, 1-cycle latency: on transfer, next cycle wr_en=1, wr_addr=addr, wr_data=data. With no transfer, next cycle wr_en=0 and wr_addr/wr_data hold their previous values.
- Register 0: a transfer with addr==0 is accepted (ready=1) but produces wr_en=0 the next cycle.
- Scoreboard, pending[31:0]:
  - issue_ready = !reset & !pending[issue_reg] & (out_count<MAX_OUT) & (issue_reg!=0).
  - Exception: issue_reg==0 gives issue_ready=1 with no effect (load to r0 is discarded, never tracked).
  - Issue accept (issue_valid & issue_ready, reg!=0): pending[reg] <= 1, out_count increments.
  - Load transfer with pending[ld_addr]=1: pending[ld_addr] <= 0, out_count decrements.
  - Load transfer with pending[ld_addr]=0: the write still happens; the scoreboard is unchanged and no underflow occurs.
  - Issue accept and load clear in the same cycle on different regs: both apply; out_count is unchanged net.
  - Same reg cannot collide: issue_ready=0 while pending.
- rs_pending = pending[rs_addr], rt_pending = pending[rt_addr], read from registered state only. There is no same-cycle clear bypass: a register clears the cycle after its load is granted, which is also the cycle wr_en writes it.
- Reset mid-operation: the in-flight write is dropped (wr_en=0 next cycle) and all pending bits are cleared.

Decomposition:
- Shared package:
  - ADDR_W, DATA_W constants
  - REQ_ALU=0, REQ_LD=1 requester index constants
  - REG_ZERO constant
- Sub-module rr_arb2: a 2-way round-robin arbiter (valid[1:0] in, grant[1:0] out, rr_last state). It is reused later for the memory port.
- Scoreboard and write register stay in the top module.

Test Plan:
- Reset: hold reset=1 for 2 cycles with alu_valid=1 -> alu_ready=0, wr_en=0, out_count=0, rs_pending=0.
- Single ALU: alu_valid=1, alu_addr=5, alu_data=32'hDEADBEEF -> alu_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=DEADBEEF; following cycle wr_en=0.
- Contention: both valid for 4 consecutive cycles with new data each grant -> grant order ALU, LD, ALU, LD, and wr_data matches that order.
- Scoreboard: issue load to r8 -> rs_addr=8 gives rs_pending=1. A second issue to r8 gives issue_ready=0. ld_valid with addr 8 is granted -> next cycle rs_pending=0 and wr_en=1 to r8.
- Capacity: issue loads to r1..r4 -> out_count=4, issue to r9 gives issue_ready=0. Return r2 and issue r9 in the same cycle -> issue_ready still 0 that cycle, accepted the next; out_count stays 4.
- r0 and mid-op reset: alu_addr=0 -> alu_ready=1, no wr_en. Issue r3, then assert reset -> pending cleared, out_count=0, wr_en=0.
